mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 17, word address width (bit 16 = bank select); DATA_W, default 32, data width; RD_LAT, default 1, RAM read latency in cycles.
REQ-002 Clk  in  1  single clock; all state changes on rising edge.
REQ-003 Rst_n  in  1  reset, asynchronous, active-low.
REQ-004 P_Req, P_We  in  1 each  processor request; write when P_We=1.
REQ-005 P_Addr  in  ADDR_W  processor word address; P_Wdata  in  DATA_W  processor write data.
REQ-006 P_Gnt  out  1  processor request accepted this cycle.
REQ-007 P_Rvalid  out  1  processor read data valid; P_Rdata  out  DATA_W  processor read data.
REQ-008 L_Req, L_We, L_Addr, L_Wdata, L_Gnt, L_Rvalid, L_Rdata: loader port, same widths and meaning as the processor port.
REQ-009 L_Done  in  1  single-cycle pulse, loader finished boot image.
REQ-010 Proc_Run  out  1  processor may fetch and execute; P_Stall  out  1  = P_Req and not P_Gnt.
REQ-011 Ram_Addr  out  16  bank word address; Ram_Wdata  out  DATA_W.
REQ-012 Ram0_Rden, Ram0_Wren, Ram1_Rden, Ram1_Wren  out  1 each  per-bank strobes.
REQ-013 Ram0_Rdata, Ram1_Rdata  in  DATA_W  bank read data, valid RD_LAT cycles after Rden.

Function
REQ-014 FSM states: BOOT, RUN, DRAIN; reset state BOOT.
REQ-015 BOOT: only loader is granted (L_Gnt = L_Req); P_Gnt=0; Proc_Run=0.
REQ-016 BOOT -> DRAIN on L_Done; a loader request in the L_Done cycle is still granted.
REQ-017 DRAIN: no grants; -> RUN when no read is in flight; DRAIN lasts ≥1 cycle.
REQ-018 RUN: Proc_Run=1; round-robin arbitration; with both requesting, the port not granted last in RUN wins; a single requester always wins; first contention after entering RUN goes to processor.
REQ-019 Grant is combinational in the request cycle; at most one of P_Gnt/L_Gnt is high per cycle.
REQ-020 On grant: Ram_Addr = winner Addr[15:0]; bank = Addr[16]; only that bank's Wren (We=1) or Rden (We=0) is high, for exactly one cycle; all strobes low otherwise.
REQ-021 Read return: owner and bank tag enter an RD_LAT-deep shift register; exactly RD_LAT cycles after grant, the owner's Rvalid pulses for one cycle and its Rdata = selected bank's Rdata.
REQ-022 Rdata of a port holds its last valid value when Rvalid=0.
REQ-023 Back-to-back reads from either port every cycle are supported with no bubbles.
REQ-024 Writes produce no Rvalid.
REQ-025 L_Done outside BOOT is ignored; loader then competes as a normal requester in RUN.

Reset
REQ-026 Rst_n low, any cycle: state=BOOT, last-grant=loader, tag pipeline cleared, all strobes, Gnt, Rvalid, Proc_Run low, Rdata outputs zero; in-flight reads are discarded with no Rvalid.
REQ-027 Outputs take reset values asynchronously on Rst_n falling; first grant possible in the first rising edge cycle after Rst_n rises.

Structure
REQ-028 Shared package holds the state enumeration (BOOT, RUN, DRAIN), owner encoding (OWN_P, OWN_L) and default widths.
REQ-029 One sub-module, rd_tag_pipe: RD_LAT-deep valid/owner/bank shift register; arbitration and FSM stay in the top.

Verification
REQ-030 Reset, L_Req write 0x00005=0xDEADBEEF with P_Req=1 -> L_Gnt=1, Ram0_Wren=1, Ram_Addr=0x0005, P_Gnt=0, P_Stall=1, Proc_Run=0.
REQ-031 L_Done pulse with no reads in flight -> one DRAIN cycle, then Proc_Run=1 and P_Gnt on the next P_Req.
REQ-032 RUN, P and L both read for 4 cycles -> grants P,L,P,L; each Rvalid RD_LAT cycles after its grant, to the correct port only.
REQ-033 P read addr 0x10003 (Ram1_Rdata=0x12345678) -> Ram1_Rden=1, Ram0 strobes 0, P_Rvalid with P_Rdata=0x12345678 after RD_LAT cycles.
REQ-034 L_Done in the same cycle as a loader read -> read granted, DRAIN held until L_Rvalid, then RUN.
REQ-035 Rst_n low during an in-flight read -> no Rvalid afterwards, state BOOT, Proc_Run=0 immediately.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared constants and types for the memory port arbiter
// Holds the FSM state codes, the port owner encoding and the default widths
// used by mem_port_arbiter and its read-tag pipeline.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 17;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_RD_LAT = 1;

    // Word address bit that selects between the two RAM banks.
    localparam int BANK_BIT   = 16;
    localparam int RAM_ADDR_W = 16;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic {
        OWN_P = 1'b0,
        OWN_L = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// rtl/mem_port_arbiter_rd_tag_pipe.sv - RD_LAT-deep valid/owner/bank tag shift register
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset (clears all tags)
//   push_valid/owner/bank           tag of a read granted this cycle
//   pop_valid/owner/bank            tag of the read whose RAM data is on the bank outputs now
//   pending                         a read is still outstanding beyond the current cycle
module mem_port_arbiter_rd_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_valid,
    input  owner_t push_owner,
    input  logic   push_bank,
    output logic   pop_valid,
    output owner_t pop_owner,
    output logic   pop_bank,
    output logic   pending
);

    logic [RD_LAT-1:0] valid_q, valid_d;
    logic [RD_LAT-1:0] owner_q, owner_d;
    logic [RD_LAT-1:0] bank_q,  bank_d;

    always_comb begin
        valid_d    = '0;
        owner_d    = '0;
        bank_d     = '0;
        valid_d[0] = push_valid;
        owner_d[0] = push_owner;
        bank_d[0]  = push_bank;
        for (int i = 1; i < RD_LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            owner_d[i] = owner_q[i-1];
            bank_d[i]  = bank_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            owner_q <= '0;
            bank_q  <= '0;
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
            bank_q  <= bank_d;
        end
    end

    assign pop_valid = valid_q[RD_LAT-1];
    assign pop_owner = owner_t'(owner_q[RD_LAT-1]);
    assign pop_bank  = bank_q[RD_LAT-1];

    // The last stage returns its data in the current cycle, so only the
    // earlier stages still count as outstanding once this cycle ends.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            pending = pending | valid_q[i];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - processor/loader arbiter onto a two-bank single-port RAM
// Ports:
//   Clk, Rst_n              clock, asynchronous active-low reset
//   P_Req/We/Addr/Wdata     processor request; P_Gnt accept, P_Rvalid/P_Rdata read return
//   L_Req/We/Addr/Wdata     loader request;    L_Gnt accept, L_Rvalid/L_Rdata read return
//   L_Done                  one-cycle pulse: loader has finished the boot image
//   Proc_Run, P_Stall       processor may execute / processor request held off
//   Ram_Addr, Ram_Wdata     shared bank word address and write data
//   Ram0_*/Ram1_*           per-bank read/write strobes and read data
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  P_Req,
    input  logic                  P_We,
    input  logic [ADDR_W-1:0]     P_Addr,
    input  logic [DATA_W-1:0]     P_Wdata,
    output logic                  P_Gnt,
    output logic                  P_Rvalid,
    output logic [DATA_W-1:0]     P_Rdata,
    input  logic                  L_Req,
    input  logic                  L_We,
    input  logic [ADDR_W-1:0]     L_Addr,
    input  logic [DATA_W-1:0]     L_Wdata,
    output logic                  L_Gnt,
    output logic                  L_Rvalid,
    output logic [DATA_W-1:0]     L_Rdata,
    input  logic                  L_Done,
    output logic                  Proc_Run,
    output logic                  P_Stall,
    output logic [RAM_ADDR_W-1:0] Ram_Addr,
    output logic [DATA_W-1:0]     Ram_Wdata,
    output logic                  Ram0_Rden,
    output logic                  Ram0_Wren,
    output logic                  Ram1_Rden,
    output logic                  Ram1_Wren,
    input  logic [DATA_W-1:0]     Ram0_Rdata,
    input  logic [DATA_W-1:0]     Ram1_Rdata
);

    logic [1:0]        state_q, state_d;
    owner_t            last_q, last_d;
    logic [DATA_W-1:0] p_rdata_q, p_rdata_d;
    logic [DATA_W-1:0] l_rdata_q, l_rdata_d;

    logic              p_gnt, l_gnt, gnt_any;
    logic              win_we, win_bank;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    owner_t            win_owner;

    logic              pop_valid, pop_bank, rd_pending;
    owner_t            pop_owner;
    logic [DATA_W-1:0] ret_data;

    // Grants are gated by Rst_n so nothing is accepted while reset is held,
    // even though BOOT would otherwise pass L_Req straight through.
    always_comb begin
        p_gnt = 1'b0;
        l_gnt = 1'b0;
        if (Rst_n) begin
            case (state_q)
                ST_BOOT: l_gnt = L_Req;
                ST_RUN: begin
                    if (P_Req && L_Req) begin
                        if (last_q == OWN_P) l_gnt = 1'b1;
                        else                 p_gnt = 1'b1;
                    end else begin
                        p_gnt = P_Req;
                        l_gnt = L_Req;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt_any = p_gnt || l_gnt;
    assign P_Gnt   = p_gnt;
    assign L_Gnt   = l_gnt;
    assign P_Stall = P_Req && !p_gnt;

    always_comb begin
        if (l_gnt) begin
            win_we    = L_We;
            win_addr  = L_Addr;
            win_wdata = L_Wdata;
            win_owner = OWN_L;
        end else begin
            win_we    = P_We;
            win_addr  = P_Addr;
            win_wdata = P_Wdata;
            win_owner = OWN_P;
        end
    end

    assign win_bank  = win_addr[BANK_BIT];
    assign Ram_Addr  = gnt_any ? win_addr[RAM_ADDR_W-1:0] : '0;
    assign Ram_Wdata = (gnt_any && win_we) ? win_wdata : '0;
    assign Ram0_Wren = gnt_any &&  win_we && !win_bank;
    assign Ram1_Wren = gnt_any &&  win_we &&  win_bank;
    assign Ram0_Rden = gnt_any && !win_we && !win_bank;
    assign Ram1_Rden = gnt_any && !win_we &&  win_bank;

    mem_port_arbiter_rd_tag_pipe #(
        .RD_LAT     (RD_LAT)
    ) u_rd_tag_pipe (
        .clk        (Clk),
        .rst_n      (Rst_n),
        .push_valid (gnt_any && !win_we),
        .push_owner (win_owner),
        .push_bank  (win_bank),
        .pop_valid  (pop_valid),
        .pop_owner  (pop_owner),
        .pop_bank   (pop_bank),
        .pending    (rd_pending)
    );

    // Returning data passes straight through in its Rvalid cycle and is
    // captured so each port keeps showing its last read afterwards.
    assign ret_data = pop_bank ? Ram1_Rdata : Ram0_Rdata;
    assign P_Rvalid = pop_valid && (pop_owner == OWN_P);
    assign L_Rvalid = pop_valid && (pop_owner == OWN_L);
    assign P_Rdata  = P_Rvalid ? ret_data : p_rdata_q;
    assign L_Rdata  = L_Rvalid ? ret_data : l_rdata_q;
    assign Proc_Run = (state_q == ST_RUN);

    always_comb begin
        p_rdata_d = P_Rdata;
        l_rdata_d = L_Rdata;
    end

    // last_q is forced to the loader while draining so the first contention
    // in RUN always favours the processor.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_BOOT: begin
                if (L_Done) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                last_d = OWN_L;
                if (!rd_pending) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (gnt_any) last_d = win_owner;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ST_BOOT;
            last_q    <= OWN_L;
            p_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            p_rdata_q <= p_rdata_d;
            l_rdata_q <= l_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 1;

    logic              Clk = 1'b0;
    logic              Rst_n = 1'b0;
    logic              P_Req = 1'b0, P_We = 1'b0;
    logic [ADDR_W-1:0] P_Addr = '0;
    logic [DATA_W-1:0] P_Wdata = '0;
    logic              P_Gnt, P_Rvalid;
    logic [DATA_W-1:0] P_Rdata;
    logic              L_Req = 1'b0, L_We = 1'b0;
    logic [ADDR_W-1:0] L_Addr = '0;
    logic [DATA_W-1:0] L_Wdata = '0;
    logic              L_Gnt, L_Rvalid;
    logic [DATA_W-1:0] L_Rdata;
    logic              L_Done = 1'b0;
    logic              Proc_Run, P_Stall;
    logic [15:0]       Ram_Addr;
    logic [DATA_W-1:0] Ram_Wdata;
    logic              Ram0_Rden, Ram0_Wren, Ram1_Rden, Ram1_Wren;
    logic [DATA_W-1:0] Ram0_Rdata = '0, Ram1_Rdata = '0;

    always #5 Clk = ~Clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .P_Req(P_Req), .P_We(P_We), .P_Addr(P_Addr), .P_Wdata(P_Wdata),
        .P_Gnt(P_Gnt), .P_Rvalid(P_Rvalid), .P_Rdata(P_Rdata),
        .L_Req(L_Req), .L_We(L_We), .L_Addr(L_Addr), .L_Wdata(L_Wdata),
        .L_Gnt(L_Gnt), .L_Rvalid(L_Rvalid), .L_Rdata(L_Rdata),
        .L_Done(L_Done), .Proc_Run(Proc_Run), .P_Stall(P_Stall),
        .Ram_Addr(Ram_Addr), .Ram_Wdata(Ram_Wdata),
        .Ram0_Rden(Ram0_Rden), .Ram0_Wren(Ram0_Wren),
        .Ram1_Rden(Ram1_Rden), .Ram1_Wren(Ram1_Wren),
        .Ram0_Rdata(Ram0_Rdata), .Ram1_Rdata(Ram1_Rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input int key);
        return 32'h5A00_0000 ^ key;
    endfunction

    // Bank RAMs driven by the DUT strobes, with RD_LAT cycles of read latency.
    logic [31:0] ram_mem [int];
    logic [31:0] r0_nxt = '0, r1_nxt = '0;
    logic [31:0] r0_pipe [RD_LAT];
    logic [31:0] r1_pipe [RD_LAT];
    int          ram_cyc = 0;
    int          k0, k1;

    function automatic logic [31:0] ram_rd(input int key);
        if (ram_mem.exists(key)) return ram_mem[key];
        return init_val(key);
    endfunction

    always @(negedge Clk) begin
        k0 = int'(Ram_Addr);
        k1 = 32'h10000 | int'(Ram_Addr);
        if (Ram0_Wren) ram_mem[k0] = Ram_Wdata;
        if (Ram1_Wren) ram_mem[k1] = Ram_Wdata;
        r0_nxt = Ram0_Rden ? ram_rd(k0) : (32'hEE00_0000 | ram_cyc);
        r1_nxt = Ram1_Rden ? ram_rd(k1) : (32'hEF00_0000 | ram_cyc);
        ram_cyc++;
    end

    always @(posedge Clk) begin
        #1;
        for (int i = RD_LAT - 1; i > 0; i--) begin
            r0_pipe[i] = r0_pipe[i-1];
            r1_pipe[i] = r1_pipe[i-1];
        end
        r0_pipe[0] = r0_nxt;
        r1_pipe[0] = r1_nxt;
        Ram0_Rdata = r0_pipe[RD_LAT-1];
        Ram1_Rdata = r1_pipe[RD_LAT-1];
    end

    // Reference model: mode 0=boot 1=drain 2=run, a queue of expected read
    // returns with their due cycle, and its own copy of memory contents.
    typedef struct {
        int          due;
        bit          own_l;
        logic [31:0] data;
    } ret_t;

    ret_t        m_q[$];
    logic [31:0] mdl_mem [int];
    int          m_state = 0;
    bit          m_last_l = 1'b1;
    int          m_cyc = 0;
    logic [31:0] m_prd = '0, m_lrd = '0;

    function automatic logic [31:0] mdl_rd(input int key);
        if (mdl_mem.exists(key)) return mdl_mem[key];
        return init_val(key);
    endfunction

    bit          e_pg, e_lg, e_prv, e_lrv, w_we, w_bank;
    logic [15:0] w_addr;
    logic [31:0] w_wd;
    ret_t        r;
    int          key;

    always @(negedge Clk) begin
        if (!Rst_n) begin
            m_state  = 0;
            m_last_l = 1'b1;
            m_q.delete();
            m_prd    = '0;
            m_lrd    = '0;
        end
        e_pg = 1'b0;
        e_lg = 1'b0;
        if (Rst_n) begin
            if (m_state == 0) begin
                e_lg = L_Req;
            end else if (m_state == 2) begin
                if (P_Req && L_Req) begin
                    e_pg = m_last_l;
                    e_lg = !m_last_l;
                end else begin
                    e_pg = P_Req;
                    e_lg = L_Req;
                end
            end
        end
        w_we   = e_lg ? L_We : P_We;
        w_bank = e_lg ? L_Addr[16] : P_Addr[16];
        w_addr = e_lg ? L_Addr[15:0] : P_Addr[15:0];
        w_wd   = e_lg ? L_Wdata : P_Wdata;
        e_prv  = 1'b0;
        e_lrv  = 1'b0;
        if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
            r = m_q.pop_front();
            if (r.own_l) begin e_lrv = 1'b1; m_lrd = r.data; end
            else         begin e_prv = 1'b1; m_prd = r.data; end
        end

        chk("p_gnt", P_Gnt, e_pg);
        chk("l_gnt", L_Gnt, e_lg);
        chk("p_stall", P_Stall, P_Req && !e_pg);
        chk("proc_run", Proc_Run, Rst_n && m_state == 2);
        chk("ram0_wren", Ram0_Wren, (e_pg || e_lg) &&  w_we && !w_bank);
        chk("ram1_wren", Ram1_Wren, (e_pg || e_lg) &&  w_we &&  w_bank);
        chk("ram0_rden", Ram0_Rden, (e_pg || e_lg) && !w_we && !w_bank);
        chk("ram1_rden", Ram1_Rden, (e_pg || e_lg) && !w_we &&  w_bank);
        if (e_pg || e_lg) chk("ram_addr", Ram_Addr, w_addr);
        if ((e_pg || e_lg) && w_we) chk("ram_wdata", Ram_Wdata, w_wd);
        chk("p_rvalid", P_Rvalid, e_prv);
        chk("l_rvalid", L_Rvalid, e_lrv);
        chk("p_rdata", P_Rdata, m_prd);
        chk("l_rdata", L_Rdata, m_lrd);

        if (Rst_n) begin
            if (e_pg || e_lg) begin
                key = (int'(w_bank) << 16) | int'(w_addr);
                if (w_we) begin
                    mdl_mem[key] = w_wd;
                end else begin
                    r.due   = m_cyc + RD_LAT;
                    r.own_l = e_lg;
                    r.data  = mdl_rd(key);
                    m_q.push_back(r);
                end
                if (m_state == 2) m_last_l = e_lg;
            end
            case (m_state)
                0:       if (L_Done) m_state = 1;
                1:       if (m_q.size() == 0) m_state = 2;
                default: ;
            endcase
        end
        m_cyc++;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_p(input bit req, input bit we, input logic [16:0] addr, input logic [31:0] wd);
        P_Req = req; P_We = we; P_Addr = addr; P_Wdata = wd;
    endtask

    task automatic set_l(input bit req, input bit we, input logic [16:0] addr, input logic [31:0] wd);
        L_Req = req; L_We = we; L_Addr = addr; L_Wdata = wd;
    endtask

    task automatic idle();
        set_p(0, 0, '0, '0);
        set_l(0, 0, '0, '0);
        L_Done = 1'b0;
    endtask

    logic [16:0] p_addrs [4] = '{17'h00005, 17'h00007, 17'h10003, 17'h1ABCD};
    logic [16:0] l_addrs [4] = '{17'h00009, 17'h10003, 17'h0FFFF, 17'h00005};

    initial begin
        // Reset with a loader request pending: nothing may be granted.
        set_l(1, 0, 17'h00001, '0);
        #1;
        chk("rst_l_gnt", L_Gnt, 1'b0);
        chk("rst_proc_run", Proc_Run, 1'b0);
        repeat (3) tick();
        Rst_n = 1'b1;

        // Boot: loader owns the RAM, processor stalls.
        set_l(1, 1, 17'h00005, 32'hDEADBEEF);
        set_p(1, 0, 17'h00001, '0);
        #1;
        chk("boot_l_gnt", L_Gnt, 1'b1);
        chk("boot_ram0_wren", Ram0_Wren, 1'b1);
        chk("boot_ram1_wren", Ram1_Wren, 1'b0);
        chk("boot_ram_addr", Ram_Addr, 16'h0005);
        chk("boot_p_gnt", P_Gnt, 1'b0);
        chk("boot_p_stall", P_Stall, 1'b1);
        chk("boot_proc_run", Proc_Run, 1'b0);
        tick();
        set_l(1, 1, 17'h10003, 32'h12345678);
        tick();
        set_l(1, 0, 17'h00005, '0);
        tick();
        set_l(0, 0, '0, '0);
        #1;
        chk("boot_l_rvalid", L_Rvalid, 1'b1);
        chk("boot_l_rdata", L_Rdata, 32'hDEADBEEF);
        idle();
        tick();

        // L_Done with nothing in flight: one DRAIN cycle, then RUN.
        L_Done = 1'b1;
        tick();
        L_Done = 1'b0;
        set_p(1, 0, p_addrs[0], '0);
        set_l(1, 0, l_addrs[0], '0);
        #1;
        chk("drain_proc_run", Proc_Run, 1'b0);
        chk("drain_p_gnt", P_Gnt, 1'b0);
        chk("drain_l_gnt", L_Gnt, 1'b0);
        tick();

        // Contention on entering RUN: P, L, P, L.
        for (int i = 0; i < 4; i++) begin
            set_p(1, 0, p_addrs[i], '0);
            set_l(1, 0, l_addrs[i], '0);
            #1;
            chk("rr_p_gnt", P_Gnt, (i % 2) == 0);
            chk("rr_l_gnt", L_Gnt, (i % 2) == 1);
            if (i == 0) chk("run_proc_run", Proc_Run, 1'b1);
            if (i == 1) begin
                chk("rr_p_ret_valid", P_Rvalid, 1'b1);
                chk("rr_p_ret_data", P_Rdata, 32'hDEADBEEF);
                chk("rr_l_ret_valid", L_Rvalid, 1'b0);
            end
            tick();
        end
        idle();
        tick();

        // Processor read from bank 1.
        set_p(1, 0, 17'h10003, '0);
        #1;
        chk("b1_ram1_rden", Ram1_Rden, 1'b1);
        chk("b1_ram0_rden", Ram0_Rden, 1'b0);
        chk("b1_ram0_wren", Ram0_Wren, 1'b0);
        tick();
        idle();
        #1;
        chk("b1_p_rvalid", P_Rvalid, 1'b1);
        chk("b1_p_rdata", P_Rdata, 32'h12345678);
        chk("b1_l_rvalid", L_Rvalid, 1'b0);
        tick();

        // L_Done in RUN is ignored; loader is a normal requester.
        L_Done = 1'b1;
        set_l(1, 1, 17'h00020, 32'hA5A5_0001);
        #1;
        chk("run_l_gnt", L_Gnt, 1'b1);
        tick();
        idle();
        #1;
        chk("run_ldone_proc_run", Proc_Run, 1'b1);

        // Back-to-back processor reads with no bubbles.
        for (int i = 0; i < 4; i++) begin
            set_p(1, 0, (i % 2 == 0) ? 17'h00020 : p_addrs[i], '0);
            tick();
        end
        idle();
        repeat (2) tick();

        // Write and read of the same word under contention: L(old), P(write), L(new).
        set_p(1, 1, 17'h10040, 32'h0BADCAFE);
        set_l(1, 0, 17'h10040, '0);
        repeat (3) tick();
        idle();
        #1;
        chk("wr_rd_l_rdata", L_Rdata, 32'h0BADCAFE);
        tick();

        // Loader read in the L_Done cycle holds DRAIN until it returns.
        Rst_n = 1'b0;
        repeat (2) tick();
        Rst_n = 1'b1;
        set_l(1, 0, 17'h00005, '0);
        L_Done = 1'b1;
        #1;
        chk("ld_rd_l_gnt", L_Gnt, 1'b1);
        tick();
        idle();
        #1;
        chk("ld_rd_drain_run", Proc_Run, 1'b0);
        chk("ld_rd_l_rvalid", L_Rvalid, 1'b1);
        chk("ld_rd_l_rdata", L_Rdata, 32'hDEADBEEF);
        tick();
        chk("ld_rd_run", Proc_Run, 1'b1);

        // Reset while a granted read is in flight.
        set_p(1, 0, 17'h10003, '0);
        #1;
        chk("inflt_p_gnt", P_Gnt, 1'b1);
        @(negedge Clk);
        #1;
        Rst_n = 1'b0;
        #1;
        chk("inflt_rst_proc_run", Proc_Run, 1'b0);
        chk("inflt_rst_p_gnt", P_Gnt, 1'b0);
        chk("inflt_rst_p_rvalid", P_Rvalid, 1'b0);
        tick();
        chk("inflt_no_rvalid", P_Rvalid, 1'b0);
        chk("inflt_p_rdata", P_Rdata, 32'h0);
        idle();
        tick();
        Rst_n = 1'b1;
        tick();
        chk("post_rst_proc_run", Proc_Run, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
